samp_play: RTL and testbench

- Transmit-direction counterpart of the capture path: MCU writes 16-bit words in batches; the block packs them into 128-bit sample words and buffers them in block RAM.
- Sample side (AD9361 DAC) pulls each committed batch at its own request rate.
- Single clock domain, wr_clk; MCU strobes are already synchronized into this domain upstream.
- A batch is released for playback only after it has been completely committed.

---
 rtl/samp_pkg.sv | 33 +++
 rtl/samp_sfifo.sv | 75 +++++++
 rtl/samp_play.sv | 193 +++++++++++++++++++
 tb/tb_samp_play.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/samp_pkg.sv
// Shared constants, types and helpers for the sample playback path.
// Optional build macro used by samp_play: SAMP_PLAY_CNT_EN.
package samp_pkg;

    localparam int WIDTH_IN   = 16;
    localparam int WIDTH_OUT  = 128;
    localparam int DEPTH_MULT = WIDTH_OUT / WIDTH_IN;
    localparam int LANE_W     = $clog2(DEPTH_MULT);

    localparam logic [WIDTH_OUT-1:0] MARKER = {WIDTH_OUT{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } play_state_e;

    typedef struct packed {
        logic                 tag;
        logic [WIDTH_OUT-1:0] data;
    } samp_entry_t;

    function automatic logic [WIDTH_OUT-1:0] lane_put(
        input logic [WIDTH_OUT-1:0] word,
        input logic [WIDTH_IN-1:0]  val,
        input logic [LANE_W-1:0]    idx
    );
        logic [WIDTH_OUT-1:0] res;
        res = word;
        res[int'(idx) * WIDTH_IN +: WIDTH_IN] = val;
        return res;
    endfunction

endpackage

// File: rtl/samp_sfifo.sv
// Generic synchronous first-word-fall-through FIFO with a registered head.
// The head register is reloaded from RAM every cycle, with write bypass when the slot being read is written.
module samp_sfifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             wr_clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             empty
);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] head_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_addr_s;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nx_s;
    logic             rd_s;
    logic             wr_s;

    // Accept/pop qualification and next read address
    always_comb begin
        rd_s      = rd_en & (count_r != {(AW+1){1'b0}});
        wr_s      = wr_en & ((count_r != DEPTH_CNT) | rd_s);
        rd_addr_s = rd_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        case ({wr_s, rd_s})
            2'b10:   count_nx_s = count_r + CNT_ONE;
            2'b01:   count_nx_s = count_r - CNT_ONE;
            default: count_nx_s = count_r;
        endcase
    end

    // Storage array, left unreset so it maps to block RAM
    always_ff @(posedge wr_clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and head register
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            head_r   <= {WIDTH{1'b0}};
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r <= rd_addr_s;
            count_r  <= count_nx_s;
            if (wr_s && (wr_ptr_r == rd_addr_s)) begin
                head_r <= wr_data;
            end else begin
                head_r <= mem_r[rd_addr_s];
            end
        end
    end

    assign head  = head_r;
    assign count = count_r;
    assign empty = (count_r == {(AW+1){1'b0}});

endmodule

// File: rtl/samp_play.sv
// MCU-to-DAC sample playback: packs 16-bit writes into 128-bit words and plays committed batches.
// Define SAMP_PLAY_CNT_EN to add the batch_played counter output.
module samp_play
    import samp_pkg::*;
#(
    parameter int FIFO_DEPTH = 1024
) (
    input  logic                 wr_clk,
    input  logic                 rst,
    input  logic                 wr_ena,
    input  logic [WIDTH_IN-1:0]  data_in,
    input  logic                 commit,
    output logic                 full,
    output logic                 overflow,
    input  logic                 samp_req,
    output logic                 valid,
    output logic [WIDTH_OUT-1:0] samp_out,
    output logic                 done
`ifdef SAMP_PLAY_CNT_EN
    ,
    output logic [15:0]          batch_played
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(DEPTH_MULT - 1);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
    localparam logic [AW:0]       FULL_LVL  = (AW+1)'(FIFO_DEPTH - 2);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);

    logic                 wr_ena_d_r, commit_d_r, wr_ev_s, cm_ev_s, cm_go_s;
    logic [LANE_W-1:0]    idx_r, idx_nx_s;
    logic [WIDTH_OUT-1:0] pack_r, pack_nx_s;
    logic                 cm_pend_r, mk_r, overflow_r, drop_s;
    logic [CW-1:0]        batch_cnt_r;
    logic                 push_s, pop_s, play_s, end_s, empty_s, full_s;
    samp_entry_t          push_ent_s, head_s;
    logic [AW:0]          count_s;
    play_state_e          state_r, state_nx_s;
    logic                 valid_r, done_r;
    logic [WIDTH_OUT-1:0] samp_out_r;

    // Strobe delay registers for rising-edge detection
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wr_ena_d_r <= 1'b0;
            commit_d_r <= 1'b0;
        end else begin
            wr_ena_d_r <= wr_ena;
            commit_d_r <= commit;
        end
    end

    // Events and FIFO push selection; strobe spacing keeps the three push sources apart
    always_comb begin
        wr_ev_s    = wr_ena & ~wr_ena_d_r;
        cm_ev_s    = commit & ~commit_d_r;
        cm_go_s    = (cm_ev_s & ~wr_ev_s) | cm_pend_r;
        full_s     = (count_s >= FULL_LVL);
        push_s     = 1'b0;
        drop_s     = 1'b0;
        push_ent_s = '{tag: 1'b0, data: {WIDTH_OUT{1'b0}}};
        pack_nx_s  = pack_r;
        idx_nx_s   = idx_r;
        if (mk_r) begin
            push_s     = 1'b1;
            push_ent_s = '{tag: 1'b1, data: MARKER};
        end else if (cm_go_s) begin
            push_s     = (idx_r != {LANE_W{1'b0}});
            push_ent_s = '{tag: 1'b0, data: pack_r};
        end else if (wr_ev_s && (idx_r == LANE_LAST)) begin
            push_s     = ~full_s;
            drop_s     = full_s;
            push_ent_s = '{tag: 1'b0, data: lane_put(pack_r, data_in, idx_r)};
        end else begin
            push_s = 1'b0;
        end
        if (cm_go_s) begin
            pack_nx_s = {WIDTH_OUT{1'b0}};
            idx_nx_s  = {LANE_W{1'b0}};
        end else if (wr_ev_s) begin
            if (idx_r == LANE_LAST) begin
                pack_nx_s = {WIDTH_OUT{1'b0}};
                idx_nx_s  = {LANE_W{1'b0}};
            end else begin
                pack_nx_s = lane_put(pack_r, data_in, idx_r);
                idx_nx_s  = idx_r + LANE_ONE;
            end
        end else begin
            pack_nx_s = pack_r;
        end
    end

    // Packer, commit pipeline, overflow flag and committed-batch count
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            pack_r      <= {WIDTH_OUT{1'b0}};
            idx_r       <= {LANE_W{1'b0}};
            cm_pend_r   <= 1'b0;
            mk_r        <= 1'b0;
            overflow_r  <= 1'b0;
            batch_cnt_r <= {CW{1'b0}};
        end else begin
            pack_r     <= pack_nx_s;
            idx_r      <= idx_nx_s;
            cm_pend_r  <= cm_ev_s & wr_ev_s;
            mk_r       <= cm_go_s;
            overflow_r <= overflow_r | drop_s;
            case ({mk_r, end_s})
                2'b10:   batch_cnt_r <= batch_cnt_r + CNT_ONE;
                2'b01:   batch_cnt_r <= batch_cnt_r - CNT_ONE;
                default: batch_cnt_r <= batch_cnt_r;
            endcase
        end
    end

    samp_sfifo #(
        .WIDTH ($bits(samp_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .wr_clk  (wr_clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data (push_ent_s),
        .rd_en   (pop_s),
        .head    (head_s),
        .count   (count_s),
        .empty   (empty_s)
    );

    // Playback state register
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Playback next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = (batch_cnt_r != {CW{1'b0}}) ? PLAY : IDLE;
            PLAY:    state_nx_s = end_s ? IDLE : PLAY;
            default: state_nx_s = IDLE;
        endcase
    end

    // Playback pop decode
    always_comb begin
        pop_s  = (state_r == PLAY) & samp_req & ~empty_s;
        play_s = pop_s & ~head_s.tag;
        end_s  = pop_s & head_s.tag;
    end

    // Registered sample-side outputs; samp_out holds between samples
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            valid_r    <= 1'b0;
            done_r     <= 1'b0;
            samp_out_r <= {WIDTH_OUT{1'b0}};
        end else begin
            valid_r <= play_s;
            done_r  <= end_s;
            if (play_s) begin
                samp_out_r <= head_s.data;
            end
        end
    end

    assign full     = full_s;
    assign overflow = overflow_r;
    assign valid    = valid_r;
    assign done     = done_r;
    assign samp_out = samp_out_r;

`ifdef SAMP_PLAY_CNT_EN
    logic [15:0] played_r;

    // Count played batches, wrapping naturally at 16 bits
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            played_r <= 16'h0000;
        end else if (end_s) begin
            played_r <= played_r + 16'h0001;
        end
    end

    assign batch_played = played_r;
`endif

endmodule

// File: tb/tb_samp_play.sv
// Randomized self-checking bench for samp_play against a queue-based batch model.
module tb_samp_play;
    localparam int DEPTH = 16;

    logic         wr_clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_ena = 1'b0;
    logic [15:0]  data_in = 16'h0000;
    logic         commit = 1'b0;
    logic         full, overflow, valid, done;
    logic         samp_req = 1'b0;
    logic [127:0] samp_out;
`ifdef SAMP_PLAY_CNT_EN
    logic [15:0]  batch_played;
    int           played_exp = 0;
`endif

    int vectors = 0;
    int miscompares = 0;

    // model state: pending lanes of the open batch, expected samples, FIFO entries resident
    logic [15:0]  lanes[$];
    logic [127:0] exp_q[$];
    int           occ = 0;
    bit           ovf_exp = 1'b0;

    samp_play #(.FIFO_DEPTH(DEPTH)) dut (
        .wr_clk   (wr_clk),
        .rst      (rst),
        .wr_ena   (wr_ena),
        .data_in  (data_in),
        .commit   (commit),
        .full     (full),
        .overflow (overflow),
        .samp_req (samp_req),
        .valid    (valid),
        .samp_out (samp_out),
        .done     (done)
`ifdef SAMP_PLAY_CNT_EN
        ,
        .batch_played (batch_played)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    function automatic logic [127:0] pack_lanes();
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < lanes.size(); i++) w[16*i +: 16] = lanes[i];
        return w;
    endfunction

    task automatic model_clear();
        lanes.delete();
        exp_q.delete();
        occ = 0;
        ovf_exp = 1'b0;
`ifdef SAMP_PLAY_CNT_EN
        played_exp = 0;
`endif
    endtask

    task automatic mcu_write(input logic [15:0] d);
        lanes.push_back(d);
        if (lanes.size() == 8) begin
            if (occ < DEPTH - 2) begin
                exp_q.push_back(pack_lanes());
                occ++;
            end else begin
                ovf_exp = 1'b1;
            end
            lanes.delete();
        end
        data_in = d;
        wr_ena = 1'b1;
        tick();
        wr_ena = 1'b0;
        tick();
    endtask

    task automatic model_commit();
        if (lanes.size() != 0) begin
            exp_q.push_back(pack_lanes());
            occ++;
            lanes.delete();
        end
        occ++;
    endtask

    task automatic mcu_commit();
        model_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
    endtask

    // Requests the whole batch in exp_q and checks samples, gaps and the closing done pulse
    task automatic play_batch(input bit gaps, input string name);
        int n;
        int waited;
        bit req;
        logic [127:0] last;
        n = exp_q.size();
        waited = 0;
        last = '0;
        samp_req = 1'b1;
        tick();
        while (valid !== 1'b1 && done !== 1'b1 && waited < 12) begin
            tick();
            waited++;
        end
        for (int k = 0; k <= n; k++) begin
            vectors++;
            if (k < n) begin
                if (valid !== 1'b1 || done !== 1'b0 || samp_out !== exp_q[k]) begin
                    miscompares++;
                    $display("FAIL %s sample %0d: valid=%b done=%b samp_out=%h, required valid=1 done=0 samp_out=%h",
                             name, k, valid, done, samp_out, exp_q[k]);
                end
                last = exp_q[k];
            end else if (valid !== 1'b0 || done !== 1'b1) begin
                miscompares++;
                $display("FAIL %s end: valid=%b done=%b, required valid=0 done=1", name, valid, done);
            end
            if (k == n) break;
            for (int g = 0; g < 4; g++) begin
                req = !gaps || (g == 3) || ($urandom_range(0, 2) != 0);
                samp_req = req;
                tick();
                if (req) break;
                vectors++;
                if (valid !== 1'b0 || done !== 1'b0 || samp_out !== last) begin
                    miscompares++;
                    $display("FAIL %s gap: valid=%b done=%b samp_out=%h, required valid=0 done=0 samp_out=%h",
                             name, valid, done, samp_out, last);
                end
            end
        end
        samp_req = 1'b0;
        tick();
        vectors++;
        if (valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after: valid=%b done=%b, required 0 0", name, valid, done);
        end
`ifdef SAMP_PLAY_CNT_EN
        played_exp++;
        vectors++;
        if (batch_played !== 16'(played_exp)) begin
            miscompares++;
            $display("FAIL %s batch_played: got %0d, required %0d", name, batch_played, played_exp);
        end
`endif
        exp_q.delete();
        occ -= n + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (full !== 1'b0 || overflow !== 1'b0 || valid !== 1'b0 || done !== 1'b0 || samp_out !== 128'h0) begin
            miscompares++;
            $display("FAIL reset: full=%b overflow=%b valid=%b done=%b samp_out=%h, required all zero",
                     full, overflow, valid, done, samp_out);
        end
        rst = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic test_full_word();
        for (int i = 1; i <= 8; i++) mcu_write(16'(i));
        mcu_commit();
        vectors++;
        if (exp_q.size() != 1 || exp_q[0] !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin
            miscompares++;
            $display("FAIL model_pack: got %h, required 0008..0001", exp_q[0]);
        end
        play_batch(1'b0, "full_word");
    endtask

    task automatic test_partial();
        mcu_write(16'hAAAA);
        mcu_write(16'hBBBB);
        mcu_write(16'hCCCC);
        mcu_commit();
        play_batch(1'b0, "partial");
    endtask

    task automatic test_empty_batch();
        mcu_commit();
        play_batch(1'b0, "empty");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 104; i++) mcu_write(16'($urandom));
        vectors++;
        if (full !== 1'b0) begin
            miscompares++;
            $display("FAIL full_13: full=%b, required 0", full);
        end
        for (int i = 0; i < 8; i++) mcu_write(16'($urandom));
        vectors++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL full_14: full=%b overflow=%b, required 1 0", full, overflow);
        end
        for (int i = 0; i < 8; i++) mcu_write(16'($urandom));
        vectors++;
        if (overflow !== ovf_exp || exp_q.size() != 14) begin
            miscompares++;
            $display("FAIL overflow: overflow=%b words=%0d, required 1 and 14", overflow, exp_q.size());
        end
        mcu_commit();
        play_batch(1'b0, "overflow_play");
        vectors++;
        if (full !== 1'b0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky: full=%b overflow=%b, required 0 1", full, overflow);
        end
    endtask

    task automatic test_strobes();
        lanes.push_back(16'h1234);
        data_in = 16'h1234;
        wr_ena = 1'b1;
        repeat (5) tick();
        wr_ena = 1'b0;
        tick();
        mcu_commit();
        play_batch(1'b0, "held_strobe");
        mcu_write(16'h1111);
        lanes.push_back(16'h2222);
        model_commit();
        data_in = 16'h2222;
        wr_ena = 1'b1;
        commit = 1'b1;
        tick();
        wr_ena = 1'b0;
        commit = 1'b0;
        tick();
        play_batch(1'b0, "same_cycle");
    endtask

    task automatic test_reset_mid_play();
        int waited;
        for (int i = 0; i < 64; i++) mcu_write(16'($urandom));
        mcu_commit();
        samp_req = 1'b1;
        waited = 0;
        tick();
        while (valid !== 1'b1 && waited < 12) begin
            tick();
            waited++;
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (valid !== 1'b1 || samp_out !== exp_q[k]) begin
                miscompares++;
                $display("FAIL midplay sample %0d: valid=%b samp_out=%h, required 1 %h", k, valid, samp_out, exp_q[k]);
            end
            if (k < 2) tick();
        end
        rst = 1'b1;
        samp_req = 1'b0;
        tick();
        vectors++;
        if (valid !== 1'b0 || done !== 1'b0 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL midplay reset: valid=%b done=%b full=%b, required 0 0 0", valid, done, full);
        end
        rst = 1'b0;
        model_clear();
        tick();
        mcu_write(16'h5A5A);
        mcu_commit();
        play_batch(1'b0, "post_reset");
    endtask

    task automatic test_random();
        int nw;
        for (int b = 0; b < 6; b++) begin
            nw = $urandom_range(0, 40);
            for (int i = 0; i < nw; i++) mcu_write(16'($urandom));
            mcu_commit();
            play_batch(1'b1, "random");
        end
        vectors++;
        if (overflow !== ovf_exp) begin
            miscompares++;
            $display("FAIL random_overflow: overflow=%b, required %b", overflow, ovf_exp);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_empty_batch();
        test_strobes();
        test_reset_mid_play();
        test_random();
        test_overflow();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
